bram_snapshot_ctrl: RTL and testbench
=====================================

# bram_snapshot_ctrl

Controller that sequences the 144-bit game-state BRAM as a circular snapshot history. Each entry holds twelve 12-bit square coordinates (x1/x2/y1/y2 for three squares). Game logic saves one snapshot per frame and reads back any of the last 2**RAM_ADDR_BITS snapshots by age for replay or undo. The block owns the BRAM's `ram_enable`, `write_enable` and `address`, and arbitrates save, load and clear requests onto that single port.

## Interface
- RAM_ADDR_BITS, 9: BRAM address width; DEPTH = 2**RAM_ADDR_BITS = 512 entries.
- WORD_WIDTH, 12: coordinate word width.
- NUM_WORDS, 12: words per snapshot; RAM_WIDTH = WORD_WIDTH*NUM_WORDS = 144.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  level; empties the history.
- save_req  in  1  level; held until save_ack.
- save_data  in  RAM_WIDTH  snapshot; word k is in [12k+11:12k].
- load_req  in  1  level; held until load_ack.
- load_offset  in  RAM_ADDR_BITS  age of the requested snapshot; 0 is the newest.
- save_ack  out  1  one-cycle pulse.
- load_ack  out  1  one-cycle pulse.
- load_err  out  1  one-cycle pulse with load_ack when the offset is invalid.
- load_data  out  RAM_WIDTH  registered read result.
- busy  out  1  high whenever the state is not IDLE.
- count  out  RAM_ADDR_BITS+1  number of valid entries, 0..DEPTH.
- ram_enable  out  1  BRAM enable.
- write_enable  out  1  BRAM write strobe.
- address  out  RAM_ADDR_BITS  BRAM address.
- ram_wdata  out  RAM_WIDTH  BRAM write data; drives input_data..input_data11.
- ram_rdata  in  RAM_WIDTH  BRAM read data; one-cycle synchronous read latency.

## Operation
- State register: head (RAM_ADDR_BITS), count, FSM state.
- States: IDLE, WRITE, READ, RWAIT, RDONE, ERR.
- Requests are sampled only in IDLE. Priority: clear > save_req > load_req. A held save_req starves load_req; this is accepted because saves occur once per frame.
- **clear** (in IDLE): head=0 and count=0 on the next edge. Stays in IDLE with no ack and no RAM access. load_data is unchanged.
- **save**: in IDLE, latch save_data into ram_wdata and go to WRITE.
  - WRITE: ram_enable=1, write_enable=1, address=head, save_ack=1.
  - At the end of WRITE: head=head+1 (mod DEPTH, so 511 wraps to 0); count=min(count+1, DEPTH); return to IDLE.
  - When full, the save overwrites the oldest entry.
- **load**: when load_offset >= count, go to ERR.
  - ERR: load_ack=1, load_err=1, no RAM access, load_data unchanged. Then IDLE.
  - Otherwise go to READ with address=(head-1-load_offset) mod DEPTH, using RAM_ADDR_BITS-wide wrapping subtraction.
  - READ: ram_enable=1, write_enable=0.
  - RWAIT: ram_enable=0; ram_rdata is valid and is registered into load_data.
  - RDONE: load_ack=1; load_data holds until the next successful load.
- In IDLE: ram_enable=0, write_enable=0, address=0. ram_wdata holds its last value.
- Requesters drop their request on the clock edge that ends the ack cycle. A request still high in IDLE after that edge is treated as a new request.

## Timing
- Reset values: state IDLE; head=0; count=0; load_data=0; ram_wdata=0; address=0. All of ram_enable, write_enable, save_ack, load_ack, load_err and busy are 0.
- Save issued with IDLE at cycle T:
  - WRITE and save_ack at T+1.
  - IDLE at T+2, so back-to-back saves run every 2 cycles.
  - count and head are updated as seen at T+2.
- Load issued with IDLE at cycle T:
  - READ at T+1.
  - RWAIT at T+2.
  - RDONE with load_ack at T+3, with load_data valid the same cycle.
  - IDLE at T+4.
- Error load: load_ack and load_err at T+1; IDLE at T+2.
- busy is high from T+1 until the last non-IDLE cycle.
- A save and a load sampled in the same IDLE cycle: save_ack at T+1, load sampled at T+2, load_ack at T+5.
- Reset asserted at any point clears all outputs immediately, with no clock needed:
  - An in-flight WRITE is aborted with no ack, and its entry content is undefined.
  - An in-flight READ produces no ack.
  - History is emptied (count=0).

## Test plan
- Reset: hold reset_n=0 for 3 cycles -> every output 0, count=0, busy=0; release, idle 5 cycles -> ram_enable stays 0.
- Save/load: save 3 snapshots, where word k of frame f = 16f+k -> count=3. Then load offset 0 -> load_data words 32..43, with ack exactly 3 cycles after the load is sampled. Then load offset 2 -> words 0..11.
- Error: with count=3, load_offset=3 -> load_ack and load_err at T+1, ram_enable never 1, load_data unchanged.
- Wrap and full: 513 saves of frame index f -> count=512 and head=1. Load offset 0 reads address 0 (frame 512). Load offset 511 reads address 1 (frame 1).
- Collision: save_req and load_req rise in the same cycle -> save_ack at T+1, load_ack at T+5, and load_data is the just-saved snapshot.
- Reset and clear: assert reset_n=0 during READ -> no load_ack and count=0. Then save 2 and pulse clear -> count=0, and a load with offset 0 returns load_err.

Source files
------------

// File: rtl/bram_snapshot_ctrl_if.sv
// Request/response and BRAM-port signal bundle for the snapshot history
// controller. The requester/test side uses "master"; the controller uses "slave".
interface bram_snapshot_ctrl_if #(
  parameter int unsigned RAM_ADDR_BITS = 9,
  parameter int unsigned WORD_WIDTH    = 12,
  parameter int unsigned NUM_WORDS     = 12
);
  localparam int unsigned RAM_WIDTH = WORD_WIDTH * NUM_WORDS;

  logic                     clear;
  logic                     save_req;
  logic [RAM_WIDTH-1:0]     save_data;
  logic                     load_req;
  logic [RAM_ADDR_BITS-1:0] load_offset;
  logic                     save_ack;
  logic                     load_ack;
  logic                     load_err;
  logic [RAM_WIDTH-1:0]     load_data;
  logic                     busy;
  logic [RAM_ADDR_BITS:0]   count;
  logic                     ram_enable;
  logic                     write_enable;
  logic [RAM_ADDR_BITS-1:0] address;
  logic [RAM_WIDTH-1:0]     ram_wdata;
  logic [RAM_WIDTH-1:0]     ram_rdata;

  modport master (
    output clear, save_req, save_data, load_req, load_offset, ram_rdata,
    input  save_ack, load_ack, load_err, load_data, busy, count,
           ram_enable, write_enable, address, ram_wdata
  );

  modport slave (
    input  clear, save_req, save_data, load_req, load_offset, ram_rdata,
    output save_ack, load_ack, load_err, load_data, busy, count,
           ram_enable, write_enable, address, ram_wdata
  );
endinterface

// File: rtl/bram_snapshot_ctrl.sv
// Circular snapshot history controller for the game-state BRAM. Arbitrates
// clear/save/load onto the single BRAM port; loads address entries by age.
module bram_snapshot_ctrl #(
  parameter int unsigned RAM_ADDR_BITS = 9,
  parameter int unsigned WORD_WIDTH    = 12,
  parameter int unsigned NUM_WORDS     = 12
) (
  input  logic                 clock,
  input  logic                 reset_n,
  bram_snapshot_ctrl_if.slave  bus
);
  localparam int unsigned RAM_WIDTH = WORD_WIDTH * NUM_WORDS;
  localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE  = 1;
  localparam logic [RAM_ADDR_BITS:0]   COUNT_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RWAIT,
    S_RDONE,
    S_ERR
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [RAM_ADDR_BITS-1:0] r_head;
  logic [RAM_ADDR_BITS-1:0] r_rd_addr;
  logic [RAM_ADDR_BITS:0]   r_count;
  logic [RAM_WIDTH-1:0]     r_wdata;
  logic [RAM_WIDTH-1:0]     r_load_data;
  logic                     w_offset_bad;
  logic                     w_full;

  // Count never exceeds DEPTH, so the history is full exactly when its MSB is set.
  assign w_full       = r_count[RAM_ADDR_BITS];
  assign w_offset_bad = ({1'b0, bus.load_offset} >= r_count);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state: requests sampled only in IDLE, priority clear > save > load.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.clear)         w_next = S_IDLE;
        else if (bus.save_req) w_next = S_WRITE;
        else if (bus.load_req) w_next = w_offset_bad ? S_ERR : S_READ;
      end
      S_WRITE: w_next = S_IDLE;
      S_READ:  w_next = S_RWAIT;
      S_RWAIT: w_next = S_RDONE;
      S_RDONE: w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state only, so async reset clears them at once.
  always_comb begin
    bus.ram_enable   = 1'b0;
    bus.write_enable = 1'b0;
    bus.address      = '0;
    bus.save_ack     = 1'b0;
    bus.load_ack     = 1'b0;
    bus.load_err     = 1'b0;
    bus.busy         = (r_state != S_IDLE);
    case (r_state)
      S_WRITE: begin
        bus.ram_enable   = 1'b1;
        bus.write_enable = 1'b1;
        bus.address      = r_head;
        bus.save_ack     = 1'b1;
      end
      S_READ: begin
        bus.ram_enable = 1'b1;
        bus.address    = r_rd_addr;
      end
      S_RDONE: bus.load_ack = 1'b1;
      S_ERR: begin
        bus.load_ack = 1'b1;
        bus.load_err = 1'b1;
      end
      default: ;
    endcase
  end

  // History pointers, latched write data, read address and read result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head      <= '0;
      r_count     <= '0;
      r_rd_addr   <= '0;
      r_wdata     <= '0;
      r_load_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.clear) begin
            r_head  <= '0;
            r_count <= '0;
          end else if (bus.save_req) begin
            r_wdata <= bus.save_data;
          end else if (bus.load_req && !w_offset_bad) begin
            r_rd_addr <= r_head - ADDR_ONE - bus.load_offset;
          end
        end
        S_WRITE: begin
          r_head <= r_head + ADDR_ONE;
          if (!w_full) r_count <= r_count + COUNT_ONE;
        end
        S_RWAIT: r_load_data <= bus.ram_rdata;
        default: ;
      endcase
    end
  end

  assign bus.count     = r_count;
  assign bus.ram_wdata = r_wdata;
  assign bus.load_data = r_load_data;

endmodule

// File: tb/tb_bram_snapshot_ctrl.sv
// Self-checking bench: a queue-based history model predicts counts, load
// results, addresses and errors; a small synchronous BRAM sits on the port.
module tb_bram_snapshot_ctrl;
  localparam int unsigned AB    = 9;
  localparam int unsigned WW    = 12;
  localparam int unsigned NW    = 12;
  localparam int unsigned RW    = WW * NW;
  localparam int unsigned DEPTH = 2 ** AB;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  bram_snapshot_ctrl_if #(.RAM_ADDR_BITS(AB), .WORD_WIDTH(WW), .NUM_WORDS(NW)) bus ();

  bram_snapshot_ctrl #(.RAM_ADDR_BITS(AB), .WORD_WIDTH(WW), .NUM_WORDS(NW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // BRAM: one-cycle synchronous read.
  logic [RW-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (bus.ram_enable) begin
      if (bus.write_enable) mem[bus.address] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.address];
    end
  end

  // Reference model: newest snapshot at index 0.
  logic [RW-1:0] hist [$];
  int unsigned   m_head = 0;
  logic [RW-1:0] m_load_data = '0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] frame(input int unsigned f);
    logic [RW-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < NW; k++) r[WW*k +: WW] = WW'(16 * f + k);
    return r;
  endfunction

  function automatic logic [RW-1:0] rand_snap();
    logic [RW-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < NW; k++) r[WW*k +: WW] = WW'($urandom);
    return r;
  endfunction

  function automatic void model_push(input logic [RW-1:0] d);
    hist.push_front(d);
    if (hist.size() > DEPTH) void'(hist.pop_back());
    m_head = (m_head + 1) % DEPTH;
  endfunction

  function automatic void model_clear();
    hist.delete();
    m_head = 0;
  endfunction

  task automatic do_save(input logic [RW-1:0] d);
    int cyc;
    logic [AB-1:0] exp_addr;
    exp_addr = AB'(m_head);
    @(negedge clock);
    bus.save_data = d;
    bus.save_req  = 1'b1;
    cyc = 0;
    do begin
      @(posedge clock); #1; cyc++;
    end while (!bus.save_ack && cyc < 10);
    check("save_lat", RW'(cyc), RW'(1));
    check("save_addr", RW'(bus.address), RW'(exp_addr));
    check("save_we", RW'(bus.write_enable), RW'(1));
    bus.save_req = 1'b0;
    model_push(d);
    @(posedge clock); #1;
    check("save_idle", RW'(bus.busy), RW'(0));
    check("save_count", RW'(bus.count), RW'(hist.size()));
  endtask

  task automatic do_load(input int unsigned off);
    int cyc;
    logic saw_en;
    logic err_exp;
    logic [AB-1:0] exp_addr;
    saw_en   = 1'b0;
    err_exp  = (off >= hist.size());
    exp_addr = AB'(m_head - 1 - off);
    @(negedge clock);
    bus.load_offset = AB'(off);
    bus.load_req    = 1'b1;
    cyc = 0;
    do begin
      @(posedge clock); #1; cyc++;
      if (bus.ram_enable) begin
        saw_en = 1'b1;
        check("load_addr", RW'(bus.address), RW'(exp_addr));
        check("load_we", RW'(bus.write_enable), RW'(0));
      end
    end while (!bus.load_ack && cyc < 10);
    bus.load_req = 1'b0;
    check("load_lat", RW'(cyc), RW'(err_exp ? 1 : 3));
    check("load_err", RW'(bus.load_err), RW'(err_exp));
    check("load_ram", RW'(saw_en), RW'(!err_exp));
    if (!err_exp) m_load_data = hist[off];
    check("load_data", bus.load_data, m_load_data);
    @(posedge clock); #1;
    check("load_idle", RW'(bus.busy), RW'(0));
  endtask

  task automatic do_clear();
    @(negedge clock);
    bus.clear = 1'b1;
    @(posedge clock); #1;
    check("clr_noack", RW'(bus.save_ack | bus.load_ack), RW'(0));
    check("clr_noram", RW'(bus.ram_enable), RW'(0));
    check("clr_count", RW'(bus.count), RW'(0));
    check("clr_ldata", bus.load_data, m_load_data);
    bus.clear = 1'b0;
    model_clear();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    logic [RW-1:0] d;
    bus.clear       = 1'b0;
    bus.save_req    = 1'b0;
    bus.save_data   = '0;
    bus.load_req    = 1'b0;
    bus.load_offset = '0;

    // Reset
    repeat (3) @(posedge clock);
    #1;
    check("rst_en", RW'(bus.ram_enable), RW'(0));
    check("rst_we", RW'(bus.write_enable), RW'(0));
    check("rst_acks", RW'({bus.save_ack, bus.load_ack, bus.load_err}), RW'(0));
    check("rst_busy", RW'(bus.busy), RW'(0));
    check("rst_count", RW'(bus.count), RW'(0));
    check("rst_addr", RW'(bus.address), RW'(0));
    check("rst_ldata", bus.load_data, RW'(0));
    check("rst_wdata", bus.ram_wdata, RW'(0));
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      check("idle_en", RW'(bus.ram_enable), RW'(0));
    end

    // Save/load and error
    for (int unsigned f = 0; f < 3; f++) do_save(frame(f));
    do_load(0);
    check("ld0_frame2", bus.load_data, frame(2));
    do_load(2);
    check("ld2_frame0", bus.load_data, frame(0));
    do_load(3);

    // Wrap and full
    do_clear();
    for (int unsigned f = 0; f < 513; f++) do_save(frame(f));
    check("full_count", RW'(bus.count), RW'(512));
    check("full_head", RW'(m_head), RW'(1));
    do_load(0);
    check("wrap_new", bus.load_data, frame(512));
    do_load(511);
    check("wrap_old", bus.load_data, frame(1));
    do_load(511);

    // Collision: save and load sampled together
    d = rand_snap();
    @(negedge clock);
    bus.save_data   = d;
    bus.save_req    = 1'b1;
    bus.load_offset = '0;
    bus.load_req    = 1'b1;
    cyc = 0;
    do begin
      @(posedge clock); #1; cyc++;
      if (cyc == 1) begin
        check("col_sack", RW'(bus.save_ack), RW'(1));
        bus.save_req = 1'b0;
      end
    end while (!bus.load_ack && cyc < 12);
    bus.load_req = 1'b0;
    model_push(d);
    m_load_data = d;
    check("col_lat", RW'(cyc), RW'(5));
    check("col_data", bus.load_data, d);
    @(posedge clock); #1;

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      int unsigned r;
      int unsigned lim;
      r = $urandom_range(0, 9);
      if (r < 5) do_save(rand_snap());
      else if (r < 9) begin
        lim = hist.size() + 2;
        if (lim > DEPTH - 1) lim = DEPTH - 1;
        do_load($urandom_range(0, lim));
      end else do_clear();
    end

    // Reset during READ
    if (hist.size() == 0) do_save(rand_snap());
    @(negedge clock);
    bus.load_offset = '0;
    bus.load_req    = 1'b1;
    @(posedge clock); #1;
    check("rr_read", RW'(bus.ram_enable), RW'(1));
    #2 reset_n = 1'b0;
    #1;
    check("rr_en", RW'(bus.ram_enable), RW'(0));
    check("rr_busy", RW'(bus.busy), RW'(0));
    check("rr_ack", RW'(bus.load_ack), RW'(0));
    check("rr_count", RW'(bus.count), RW'(0));
    check("rr_ldata", bus.load_data, RW'(0));
    bus.load_req = 1'b0;
    model_clear();
    m_load_data = '0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      check("rr_noack", RW'(bus.load_ack), RW'(0));
    end

    // Clear after saves
    do_save(rand_snap());
    do_save(rand_snap());
    do_clear();
    do_load(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
